// File: rtl/seq_shifter_if.sv
// Request/response bundle between the control unit and the multi-cycle shifter.
// The control unit holds the master side; the shifter holds the slave side.
interface seq_shifter_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   in1;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   out;

  modport master (
    output start, op, in1, shamt,
    input  busy, done, out
  );

  modport slave (
    input  start, op, in1, shamt,
    output busy, done, out
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA/SLA unit shifting up to STEP bits per cycle,
// with a start/busy/done handshake so the control unit can stall on long shifts.
module seq_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned STEP    = 1
) (
  input logic          clk,
  input logic          rst_n,
  seq_shifter_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SLA = 2'b11;

  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  logic [0:0]         state;
  logic [WIDTH-1:0]   data_r;
  logic [WIDTH-1:0]   out_r;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] k;
  logic [1:0]         op_r;
  logic               done_r;

  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0]   d,
    input logic [SHAMT_W-1:0] n,
    input logic [1:0]         o
  );
    logic signed [WIDTH-1:0] ds;
    logic [WIDTH-2:0]        low;
    ds  = d;
    low = d[WIDTH-2:0] << n;
    case (o)
      OP_SLL:  return d << n;
      OP_SRL:  return d >> n;
      OP_SRA:  return ds >>> n;
      OP_SLA:  return {d[WIDTH-1], low};
      default: return d;
    endcase
  endfunction

  // Final step may be shorter than STEP when the remaining count is smaller.
  always_comb begin
    k = (cnt < STEP_AMT) ? cnt : STEP_AMT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      data_r <= '0;
      out_r  <= '0;
      cnt    <= '0;
      op_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            data_r <= bus.in1;
            cnt    <= bus.shamt;
            op_r   <= bus.op;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            out_r  <= data_r;
            done_r <= 1'b1;
            state  <= IDLE;
          end else begin
            data_r <= shift_by(data_r, k, op_r);
            cnt    <= cnt - k;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = done_r;
  assign bus.out  = out_r;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: one instance at STEP=1, one at STEP=4,
// expected results queued at issue and checked by per-instance done monitors.
module tb_seq_shifter;

  typedef struct {
    logic [31:0] val;
    int unsigned cyc;
    string       nm;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int          vectors;
  int          miscompares;
  exp_t        q1[$];
  exp_t        q2[$];

  seq_shifter_if #(.WIDTH(32)) if1 ();
  seq_shifter_if #(.WIDTH(32)) if2 ();

  seq_shifter #(.WIDTH(32), .STEP(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  seq_shifter #(.WIDTH(32), .STEP(4)) u_s4 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int s, input logic [31:0] o, input logic b);
    exp_t e;
    logic empty;
    empty = (s == 1) ? (q1.size() == 0) : (q2.size() == 0);
    if (empty) begin
      check($sformatf("spurious_done_u%0d", s), 32'd1, 32'd0);
    end else begin
      if (s == 1) e = q1.pop_front();
      else        e = q2.pop_front();
      check({e.nm, "_out"}, o, e.val);
      check({e.nm, "_lat"}, cyc, e.cyc);
      check({e.nm, "_busy_excl"}, {31'd0, b}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (if1.done === 1'b1) mon(1, if1.out, if1.busy);
    if (if2.done === 1'b1) mon(2, if2.out, if2.busy);
  end

  task automatic drive(input int s, input logic st, input logic [1:0] op,
                       input logic [31:0] a, input logic [4:0] sh);
    if (s == 1) begin
      if1.start = st; if1.op = op; if1.in1 = a; if1.shamt = sh;
    end else begin
      if2.start = st; if2.op = op; if2.in1 = a; if2.shamt = sh;
    end
  endtask

  // Called just after an edge with the instance idle; returns just after E0.
  task automatic issue(input int s, input logic [1:0] op, input logic [31:0] a,
                       input logic [4:0] sh, input logic [31:0] exp, input string nm);
    exp_t e;
    int unsigned step;
    step  = (s == 1) ? 1 : 4;
    e.val = exp;
    e.cyc = cyc + 2 + (sh + step - 1) / step;
    e.nm  = nm;
    if (s == 1) q1.push_back(e);
    else        q2.push_back(e);
    drive(s, 1'b1, op, a, sh);
    @(posedge clk); #1;
    drive(s, 1'b0, 2'b00, 32'h0, 5'd0);
  endtask

  task automatic wait_done(input int s, input string nm, output int busy_cnt);
    logic d;
    busy_cnt = 0;
    d = 1'b0;
    for (int i = 0; i < 200; i++) begin
      d = (s == 1) ? if1.done : if2.done;
      if (d) break;
      if ((s == 1) ? if1.busy : if2.busy) busy_cnt++;
      @(posedge clk); #1;
    end
    if (!d) check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  int bc;

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    drive(1, 1'b0, 2'b00, 32'h0, 5'd0);
    drive(2, 1'b0, 2'b00, 32'h0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_u1", if1.out, 32'h0);
    check("rst_busy_u1", {31'd0, if1.busy}, 32'd0);
    check("rst_done_u1", {31'd0, if1.done}, 32'd0);
    check("rst_out_u4", if2.out, 32'h0);
    check("rst_busy_u4", {31'd0, if2.busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1, 2'b11, 32'h8000_0001, 5'd1, 32'h8000_0002, "t1_sla");
    wait_done(1, "t1_sla", bc);
    @(posedge clk); #1;

    issue(1, 2'b11, 32'hC000_0001, 5'd1, 32'h8000_0002, "t2_sla");
    wait_done(1, "t2_sla", bc);
    @(posedge clk); #1;

    issue(1, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, "t3_sra");
    wait_done(1, "t3_sra", bc);
    check("t3_busy_cycles", bc, 32'd32);
    @(posedge clk); #1;
    check("t3_single_pulse", {31'd0, if1.done}, 32'd0);

    issue(1, 2'b00, 32'h1234_5678, 5'd0, 32'h1234_5678, "t4_sll0");
    wait_done(1, "t4_sll0", bc);
    issue(1, 2'b01, 32'h1234_5678, 5'd4, 32'h0123_4567, "t4_b2b_srl");
    wait_done(1, "t4_b2b_srl", bc);
    check("t4_out_held", if1.out, 32'h0123_4567);
    @(posedge clk); #1;

    issue(2, 2'b00, 32'h0000_0001, 5'd7, 32'h0000_0080, "t5_sll7");
    wait_done(2, "t5_sll7", bc);
    issue(2, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, "s4_sra31");
    wait_done(2, "s4_sra31", bc);
    @(posedge clk); #1;
    issue(2, 2'b11, 32'hC000_00F0, 5'd8, 32'h8000_F000, "s4_sla8");
    wait_done(2, "s4_sla8", bc);
    @(posedge clk); #1;
    issue(2, 2'b01, 32'hFFFF_0000, 5'd16, 32'h0000_FFFF, "s4_srl16");
    wait_done(2, "s4_srl16", bc);
    @(posedge clk); #1;
    issue(2, 2'b00, 32'h0000_0001, 5'd5, 32'h0000_0020, "s4_sll5");
    wait_done(2, "s4_sll5", bc);
    @(posedge clk); #1;

    // Test 6: abort a long shift by reset after an ignored start.
    issue(1, 2'b01, 32'hF000_0000, 5'd20, 32'h0000_0F00, "t6_aborted");
    repeat (4) @(posedge clk);
    #1;
    drive(1, 1'b1, 2'b00, 32'hDEAD_BEEF, 5'd3);
    @(posedge clk); #1;
    drive(1, 1'b0, 2'b00, 32'h0, 5'd0);
    check("t6_busy_after_ignored", {31'd0, if1.busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q1.delete();
    check("t6_rst_out", if1.out, 32'h0);
    check("t6_rst_busy", {31'd0, if1.busy}, 32'd0);
    check("t6_rst_done", {31'd0, if1.done}, 32'd0);
    repeat (30) @(posedge clk);
    #1;
    issue(1, 2'b10, 32'hF000_0000, 5'd4, 32'hFF00_0000, "t6_fresh_sra");
    wait_done(1, "t6_fresh_sra", bc);
    repeat (3) @(posedge clk);
    #1;
    check("q1_drained", q1.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
